// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
//
// Execute stage for the out-of-order core. Each cycle it can take one issued
// op from a reservation station. It selects the ALU operands and computes the
// result. ALU ops take 1 cycle; multiplies take MUL_LAT cycles. The result and
// its ROB tag go to the CDB arbiter. Both sides use valid/ready handshakes.
// The branch/jump target pc_i + imm travels with every op.
//
// Optional feature macro:
//   EXEC_MUL_EN  defined   : multiply codes 16..19 are supported and the
//                            MUL_BUSY state exists.
//                undefined : no multiplier is built, codes 16..19 are
//                            illegal, and the FSM is IDLE only.
//
// Parameters:
//   WORD      datapath width (power of 2, >= 8)
//   ADDR_LEN  PC width
//   TAG_W     ROB tag width
//   MUL_LAT   multiply latency in cycles (>= 2)
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   flush          squash the in-flight multiply and the held result
//   in_valid/in_ready, in_tag, opsel1, opsel2, alu_func,
//   rs1_value, rs2_value, imm, pc_i
//                  issue side
//   out_valid/out_ready, out_tag, alu_out, pc_o, out_illegal
//                  CDB side
// -----------------------------------------------------------------------------
module exec_unit #(
  parameter int WORD     = 32,
  parameter int ADDR_LEN = 32,
  parameter int TAG_W    = 6,
  parameter int MUL_LAT  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [1:0]          opsel1,
  input  logic [1:0]          opsel2,
  input  logic [4:0]          alu_func,
  input  logic [WORD-1:0]     rs1_value,
  input  logic [WORD-1:0]     rs2_value,
  input  logic [WORD-1:0]     imm,
  input  logic [ADDR_LEN-1:0] pc_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic [WORD-1:0]     alu_out,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic                out_illegal
);

  localparam int SHW = $clog2(WORD);

  localparam logic [4:0] FN_ADD    = 5'd0;
  localparam logic [4:0] FN_SUB    = 5'd1;
  localparam logic [4:0] FN_SLL    = 5'd2;
  localparam logic [4:0] FN_SLT    = 5'd3;
  localparam logic [4:0] FN_SLTU   = 5'd4;
  localparam logic [4:0] FN_XOR    = 5'd5;
  localparam logic [4:0] FN_SRL    = 5'd6;
  localparam logic [4:0] FN_SRA    = 5'd7;
  localparam logic [4:0] FN_OR     = 5'd8;
  localparam logic [4:0] FN_AND    = 5'd9;
  localparam logic [4:0] FN_PASS   = 5'd10;
`ifdef EXEC_MUL_EN
  localparam logic [4:0] FN_MUL    = 5'd16;
  localparam logic [4:0] FN_MULH   = 5'd17;
  localparam logic [4:0] FN_MULHSU = 5'd18;
  localparam logic [4:0] FN_MULHU  = 5'd19;
`endif

  localparam logic [0:0] IDLE = 1'b0;

  if (MUL_LAT < 2 || WORD < 8) begin : g_param_check
    $error("exec_unit: MUL_LAT must be >= 2 and WORD >= 8");
  end

  // ---------------------------------------------------------------------------
  // Operand selection and target address
  // ---------------------------------------------------------------------------
  logic [WORD-1:0]     op1;
  logic [WORD-1:0]     op2;
  logic [SHW-1:0]      shamt;
  logic [ADDR_LEN-1:0] pc_target;

  always_comb begin
    // NOTE: every variable in a combinational block gets a default first, so
    // no path through the block can infer a latch.
    op1 = '0;
    op2 = '0;
    case (opsel1)
      2'd0:    op1 = rs1_value;
      2'd1:    op1 = WORD'(pc_i);
      default: op1 = '0;
    endcase
    case (opsel2)
      2'd0:    op2 = rs2_value;
      2'd1:    op2 = imm;
      2'd2:    op2 = WORD'(4);
      default: op2 = '0;
    endcase
  end

  assign shamt     = op2[SHW-1:0];
  // imm is sign-extended or truncated to the PC width; the sum wraps.
  assign pc_target = pc_i + ADDR_LEN'($signed(imm));

  // ---------------------------------------------------------------------------
  // Single-cycle ALU and opcode decode
  // ---------------------------------------------------------------------------
  logic [WORD-1:0] alu_res;
  logic            alu_ill;
`ifdef EXEC_MUL_EN
  logic            op_is_mul;
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
`ifdef EXEC_MUL_EN
    op_is_mul = 1'b0;
`endif
    case (alu_func)
      FN_ADD:  alu_res = op1 + op2;
      FN_SUB:  alu_res = op1 - op2;
      FN_SLL:  alu_res = op1 << shamt;
      FN_SLT:  alu_res = {{(WORD-1){1'b0}}, ($signed(op1) < $signed(op2))};
      FN_SLTU: alu_res = {{(WORD-1){1'b0}}, (op1 < op2)};
      FN_XOR:  alu_res = op1 ^ op2;
      FN_SRL:  alu_res = op1 >> shamt;
      FN_SRA:  alu_res = $signed(op1) >>> shamt;
      FN_OR:   alu_res = op1 | op2;
      FN_AND:  alu_res = op1 & op2;
      FN_PASS: alu_res = op2;
`ifdef EXEC_MUL_EN
      FN_MUL, FN_MULH, FN_MULHSU, FN_MULHU: op_is_mul = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic [0:0] state;
  logic       slot_free;
  logic       in_fire;
  logic       alu_fire;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) && slot_free;
  // flush wins over a same-cycle issue: the op is dropped.
  assign in_fire   = in_valid && in_ready && !flush;

`ifdef EXEC_MUL_EN
  // ---------------------------------------------------------------------------
  // Multiplier: operands are captured at issue, and the product is loaded into
  // the output register after MUL_LAT-1 busy cycles.
  // ---------------------------------------------------------------------------
  localparam logic [0:0] MUL_BUSY = 1'b1;
  localparam int         CNT_W    = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_LAT - 2);

  logic [CNT_W-1:0]    cnt;
  logic                mul_done;
  logic [WORD-1:0]     mul_a;
  logic [WORD-1:0]     mul_b;
  logic [1:0]          mul_sel;
  logic [TAG_W-1:0]    mul_tag;
  logic [ADDR_LEN-1:0] mul_pc;
  logic [2*WORD-1:0]   mul_ext_a;
  logic [2*WORD-1:0]   mul_ext_b;
  logic [2*WORD-1:0]   mul_prod;
  logic [WORD-1:0]     mul_res;

  assign alu_fire = in_fire && !op_is_mul;
  // When the output slot is still occupied, the finished product waits here.
  assign mul_done = (state == MUL_BUSY) && (cnt == LAST_CNT) && slot_free;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values regardless of block order.
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire && op_is_mul) begin
            state <= MUL_BUSY;
            cnt   <= '0;
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt != LAST_CNT) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the operand holding registers have no reset. They are qualified by
  // state and are never observed before being loaded.
  always_ff @(posedge clk) begin
    if (in_fire && op_is_mul) begin
      mul_a   <= op1;
      mul_b   <= op2;
      mul_sel <= alu_func[1:0];
      mul_tag <= in_tag;
      mul_pc  <= pc_target;
    end
  end

  // mul_sel: 0 MUL, 1 MULH (s*s), 2 MULHSU (s*u), 3 MULHU (u*u).
  // Sign- or zero-extend both operands to 2*WORD bits, then multiply once.
  always_comb begin
    mul_ext_a = {{WORD{1'b0}}, mul_a};
    mul_ext_b = {{WORD{1'b0}}, mul_b};
    if (mul_sel == 2'd1 || mul_sel == 2'd2) begin
      mul_ext_a = {{WORD{mul_a[WORD-1]}}, mul_a};
    end
    if (mul_sel == 2'd1) begin
      mul_ext_b = {{WORD{mul_b[WORD-1]}}, mul_b};
    end
    mul_prod = mul_ext_a * mul_ext_b;
    mul_res  = (mul_sel == 2'd0) ? mul_prod[WORD-1:0] : mul_prod[2*WORD-1:WORD];
  end
`else
  assign state    = IDLE;
  assign alu_fire = in_fire;
`endif

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_tag     <= '0;
      alu_out     <= '0;
      pc_o        <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      // A transfer completing on this same edge has already been counted by the CDB.
      out_valid <= 1'b0;
    end else if (alu_fire) begin
      out_valid   <= 1'b1;
      out_tag     <= in_tag;
      alu_out     <= alu_res;
      pc_o        <= pc_target;
      out_illegal <= alu_ill;
`ifdef EXEC_MUL_EN
    end else if (mul_done) begin
      out_valid   <= 1'b1;
      out_tag     <= mul_tag;
      alu_out     <= mul_res;
      pc_o        <= mul_pc;
      out_illegal <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;
  localparam int WORD = 32, ADDR_LEN = 32, TAG_W = 6, MUL_LAT = 3;

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [1:0] opsel1, opsel2;
  logic [4:0] alu_func;
  logic [WORD-1:0] rs1_value, rs2_value, imm, alu_out;
  logic [ADDR_LEN-1:0] pc_i, pc_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        ill;
    logic [5:0]  tag;
    logic [31:0] res;
    logic [31:0] pc;
  } exp_t;

  exec_unit #(.WORD(WORD), .ADDR_LEN(ADDR_LEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .opsel1(opsel1), .opsel2(opsel2), .alu_func(alu_func),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .imm(imm), .pc_i(pc_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .alu_out(alu_out),
    .pc_o(pc_o), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] sel_op1(input logic [1:0] s, input logic [31:0] r, input logic [31:0] p);
    return (s == 2'd0) ? r : (s == 2'd1) ? p : 32'd0;
  endfunction

  function automatic logic [31:0] sel_op2(input logic [1:0] s, input logic [31:0] r, input logic [31:0] im);
    return (s == 2'd0) ? r : (s == 2'd1) ? im : (s == 2'd2) ? 32'd4 : 32'd0;
  endfunction

  // Result, illegal flag and latency of one op, from the opcode table.
  function automatic void ref_exec(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic ill, output int lat);
    int sh;
`ifdef EXEC_MUL_EN
    longint sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
`endif
    sh = int'(b[4:0]);
    r = 32'd0; ill = 1'b0; lat = 1;
    case (int'(f))
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a << sh;
      3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:  r = (a < b) ? 32'd1 : 32'd0;
      5:  r = a ^ b;
      6:  r = a >> sh;
      7:  r = $signed(a) >>> sh;
      8:  r = a | b;
      9:  r = a & b;
      10: r = b;
`ifdef EXEC_MUL_EN
      16: begin pu = ua * ub;             r = pu[31:0];  lat = MUL_LAT; end
      17: begin ps = sa * sb;             r = ps[63:32]; lat = MUL_LAT; end
      18: begin ps = sa * longint'(ua);   r = ps[63:32]; lat = MUL_LAT; end
      19: begin pu = ua * ub;             r = pu[63:32]; lat = MUL_LAT; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int lat;
    ref_exec(alu_func, sel_op1(opsel1, rs1_value, pc_i), sel_op2(opsel2, rs2_value, imm), e.res, e.ill, lat);
    e.tag = in_tag;
    e.pc  = pc_i + imm;
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] f, input logic [1:0] s1, input logic [1:0] s2,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                          input logic [31:0] p, input logic [5:0] t);
    in_valid = 1'b1; alu_func = f; opsel1 = s1; opsel2 = s2;
    rs1_value = r1; rs2_value = r2; imm = im; pc_i = p; in_tag = t;
  endtask

  task automatic drive_random_op(input bit alu_only);
    int fl[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 16, 17, 18, 19, 12};
    logic [4:0] f;
    f = 5'(fl[$urandom_range(0, alu_only ? 10 : 15)]);
    if (!alu_only && $urandom_range(0, 9) == 0) f = 5'($urandom_range(20, 31));
    drive_op(f, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rand_word(), rand_word(),
             rand_word(), rand_word(), 6'($urandom_range(0, 63)));
  endtask

  // Issue one op with the CDB ready; check in_ready, latency, busy and result.
  task automatic run_single(input string name, input logic [4:0] f, input logic [1:0] s1,
                            input logic [1:0] s2, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] im, input logic [31:0] p, input logic [5:0] t);
    exp_t e;
    int lat;
    logic [31:0] dummy;
    logic dill;
    drive_op(f, s1, s2, r1, r2, im, p, t);
    out_ready = 1'b1;
    #1;
    e = expect_now();
    ref_exec(f, sel_op1(s1, r1, p), sel_op2(s2, r2, im), dummy, dill, lat);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < lat - 1; k++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL %s_busy: got out_valid=%b in_ready=%b want 0/0", name, out_valid, in_ready);
      end
      cycle();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid: got %b want 1", name, out_valid); end
    checks++; if ({out_illegal, out_tag, alu_out, pc_o} !== e) begin
      errors++; $display("FAIL %s_result: got ill=%b tag=%0d res=%h pc=%h want ill=%b tag=%0d res=%h pc=%h",
                         name, out_illegal, out_tag, alu_out, pc_o, e.ill, e.tag, e.res, e.pc);
    end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained: got %b want 0", name, out_valid); end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive_op(5'd0, 2'd0, 2'd1, 32'd1, 32'd2, 32'd3, 32'd4, 6'd5);
    cycle(); cycle();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (alu_out !== 32'd0) begin errors++; $display("FAIL reset_alu_out: got %h want 0", alu_out); end
    checks++; if (out_tag !== 6'd0) begin errors++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
    checks++; if (pc_o !== 32'd0) begin errors++; $display("FAIL reset_pc_o: got %h want 0", pc_o); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
  endtask

  task automatic test_alu();
    run_single("add_imm", 5'd0, 2'd0, 2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0, 6'd3);
    checks++; if (alu_out !== 32'd4) begin errors++; $display("FAIL add_const: got %h want 4", alu_out); end
    run_single("sra", 5'd7, 2'd0, 2'd0, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 6'd1);
    checks++; if (alu_out !== 32'hF800_0000) begin errors++; $display("FAIL sra_const: got %h want f8000000", alu_out); end
    run_single("sltu", 5'd4, 2'd0, 2'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 6'd2);
    run_single("slt", 5'd3, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 6'd4);
    run_single("sub_wrap", 5'd1, 2'd0, 2'd0, 32'd0, 32'd1, 32'd0, 32'd0, 6'd5);
    run_single("sll", 5'd2, 2'd0, 2'd1, 32'h1234_5678, 32'd0, 32'd35, 32'd0, 6'd6);
    run_single("srl", 5'd6, 2'd0, 2'd0, 32'h8000_0001, 32'd31, 32'd0, 32'd0, 6'd7);
    run_single("pc_plus4", 5'd0, 2'd1, 2'd2, 32'd9, 32'd9, 32'd16, 32'h0000_1000, 6'd8);
    run_single("pass_zero", 5'd10, 2'd2, 2'd3, 32'd9, 32'd9, 32'd9, 32'd0, 6'd9);
    run_single("illegal12", 5'd12, 2'd0, 2'd0, 32'd9, 32'd9, 32'hFFFF_FFF8, 32'h100, 6'd10);
    checks++; if (pc_o !== 32'hF8) begin errors++; $display("FAIL pc_target_const: got %h want f8", pc_o); end
    run_single("illegal31", 5'd31, 2'd0, 2'd0, 32'd9, 32'd9, 32'd0, 32'd0, 6'd11);
  endtask

  task automatic test_mul();
    run_single("mul", 5'd16, 2'd0, 2'd0, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, 6'd20);
`ifdef EXEC_MUL_EN
    checks++; if (alu_out !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_const: got %h want ffffffeb", alu_out); end
`endif
    run_single("mulhu", 5'd19, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 6'd21);
    run_single("mulh", 5'd17, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 6'd22);
    run_single("mulhsu", 5'd18, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 6'd23);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_random_op(1'b1);
      #1;
      e = expect_now();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      cycle();
      checks++; if (out_valid !== 1'b1 || {out_illegal, out_tag, alu_out, pc_o} !== e) begin
        errors++; $display("FAIL b2b_result[%0d]: got v=%b %h want v=1 %h", i, out_valid, {out_illegal, out_tag, alu_out, pc_o}, e);
      end
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_stall();
    exp_t ea, eb, ec;
    out_ready = 1'b0;
    drive_op(5'd0, 2'd0, 2'd0, $urandom, $urandom, $urandom, $urandom, 6'd1);
    #1; ea = expect_now();
    cycle();
    drive_op(5'd0, 2'd0, 2'd0, $urandom, $urandom, $urandom, $urandom, 6'd2);
    #1; eb = expect_now();
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || {out_illegal, out_tag, alu_out, pc_o} !== ea) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b %h want v=1 %h", i, out_valid, {out_illegal, out_tag, alu_out, pc_o}, ea);
      end
      cycle();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b1 || {out_illegal, out_tag, alu_out, pc_o} !== eb) begin
      errors++; $display("FAIL stall_second: got v=%b %h want v=1 %h", out_valid, {out_illegal, out_tag, alu_out, pc_o}, eb);
    end
    drive_op(5'd0, 2'd0, 2'd0, $urandom, $urandom, $urandom, $urandom, 6'd3);
    #1; ec = expect_now();
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || {out_illegal, out_tag, alu_out, pc_o} !== ec) begin
      errors++; $display("FAIL stall_third: got v=%b %h want v=1 %h", out_valid, {out_illegal, out_tag, alu_out, pc_o}, ec);
    end
    cycle();
  endtask

  task automatic test_flush();
    // Stalled ALU result is squashed; the op offered with flush is dropped.
    out_ready = 1'b0;
    drive_op(5'd0, 2'd0, 2'd0, 32'd1, 32'd2, 32'd0, 32'd0, 6'd10);
    cycle();
    drive_op(5'd0, 2'd0, 2'd0, 32'd3, 32'd4, 32'd0, 32'd0, 6'd11);
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_alu_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_alu_ready: got %b want 1", in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_alu_dropped: got %b want 0", out_valid); end
`ifdef EXEC_MUL_EN
    // Flush in MUL_BUSY with a same-cycle issue.
    drive_op(5'd16, 2'd0, 2'd0, 32'd6, 32'd7, 32'd0, 32'd0, 6'd12);
    cycle();
    drive_op(5'd0, 2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 32'd0, 6'd13);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_mul_busy: got %b want 0", in_ready); end
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_mul_ready: got %b want 1", in_ready); end
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_mul_quiet[%0d]: got %b want 0", i, out_valid); end
      cycle();
    end
    // Reset mid-multiply: no result emerges.
    drive_op(5'd16, 2'd0, 2'd0, 32'd6, 32'd7, 32'd0, 32'd0, 6'd14);
    cycle();
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mul_ready: got %b want 1", in_ready); end
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mul_quiet[%0d]: got %b want 0", i, out_valid); end
      cycle();
    end
`endif
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t held;
    bit prev_stall = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc < 1400) begin
        if ($urandom_range(0, 3) != 0) drive_random_op(1'b0);
        else in_valid = 1'b0;
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (q.size() == 0 && !prev_stall) break;
      end
      #1;
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || {out_illegal, out_tag, alu_out, pc_o} !== held) begin
          errors++; $display("FAIL rand_hold@%0d: got v=%b %h want v=1 %h", cyc, out_valid, {out_illegal, out_tag, alu_out, pc_o}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected@%0d: got %h want no result", cyc, {out_illegal, out_tag, alu_out, pc_o});
        end else begin
          if ({out_illegal, out_tag, alu_out, pc_o} !== q[0]) begin
            errors++; $display("FAIL rand_result@%0d: got %h want %h", cyc, {out_illegal, out_tag, alu_out, pc_o}, q[0]);
          end
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(expect_now());
      prev_stall = out_valid && !out_ready;
      held = {out_illegal, out_tag, alu_out, pc_o};
      cycle();
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_tag = '0; opsel1 = '0; opsel2 = '0; alu_func = '0;
    rs1_value = '0; rs2_value = '0; imm = '0; pc_i = '0;
    test_reset();
    test_alu();
    test_mul();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
